// File: rtl/axi_wr_scoreboard.sv
// AXI write snooper: captures W lanes into a result store and checks them
// against a preloaded expect store. Optional strobe masking: SCB_WSTRB_MASK_EN.
module axi_wr_scoreboard #(
  parameter int A         = 32,
  parameter int D         = 32,
  parameter int OFM_DW    = 16,
  parameter int DEPTH     = 65536,
  parameter int BASE_ADDR = 32768
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     awvalid,
  input  logic                     awready,
  input  logic [A-1:0]             awaddr,
  input  logic [7:0]               awlen,
  input  logic                     wvalid,
  input  logic                     wready,
  input  logic                     wlast,
  input  logic [D-1:0]             wdata,
  input  logic [D/8-1:0]           wstrb,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_addr,
  input  logic [OFM_DW-1:0]        exp_data,
  input  logic                     chk_start,
  input  logic [31:0]              chk_words,
  output logic                     chk_busy,
  output logic                     chk_done,
  output logic [31:0]              err_count,
  output logic [31:0]              match_count,
  output logic [31:0]              first_err_idx,
  output logic [OFM_DW-1:0]        first_err_got,
  output logic [OFM_DW-1:0]        first_err_exp,
  output logic                     burst_err,
  output logic                     range_err,
  output logic                     drop_err,
  output logic                     orphan_err
);

  localparam int LANES = D / OFM_DW;
  localparam int ROWS  = DEPTH / LANES;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int XW    = $clog2(DEPTH);
  localparam int SB    = OFM_DW / 8;

  localparam logic [A-1:0] BASE_A  = A'(BASE_ADDR);
  localparam logic [A-1:0] BPB_A   = A'(D / 8);
  localparam logic [A:0]   ROWS_A  = (A+1)'(ROWS);
  localparam logic [31:0]  LANES_W = 32'(LANES);
  localparam logic [31:0]  DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              aw_hs, w_hs, w_take;
  logic              act_q, low_q;
  logic [7:0]        beat_q, len_q;
  logic [A:0]        row0_q, w_row;
  logic [A-1:0]      aw_off, aw_row;
  logic              in_range;
  logic [LANES-1:0]  lane_en, lane_part, lane_we;
  logic [RW-1:0]     w_ridx;

  logic [ROWS-1:0][LANES-1:0] wr_bits;
  logic [OFM_DW-1:0] res_mem [LANES][ROWS];
  logic [OFM_DW-1:0] exp_mem [DEPTH];

  logic [31:0]       iss_q, n_q;
  logic              issue;
  logic [RW-1:0]     iss_ridx;
  logic [LW-1:0]     iss_lane;
  logic [XW-1:0]     iss_x;

  logic              rd_vld_q, rd_wr_q, rd_oob_q;
  logic [OFM_DW-1:0] rd_got_q, rd_exp_q;
  logic [31:0]       rd_idx_q;
  logic              mism, first_seen_q;
  logic [OFM_DW-1:0] got_v, exp_v;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign w_take   = w_hs & act_q & ~chk_busy & ~rst;
  assign aw_off   = awaddr - BASE_A;
  assign aw_row   = aw_off / BPB_A;
  assign w_row    = row0_q + {{(A-7){1'b0}}, beat_q};
  assign in_range = ~low_q & (w_row < ROWS_A);
  assign w_ridx   = RW'(w_row);
  assign lane_we  = {LANES{w_take & in_range}} & lane_en;

`ifdef SCB_WSTRB_MASK_EN
  // A lane lands only when fully strobed; a partial strobe is a protocol fault
  always_comb begin
    lane_en   = '0;
    lane_part = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_en[k]   = &wstrb[k*SB +: SB];
      lane_part[k] = (|wstrb[k*SB +: SB]) & ~lane_en[k];
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
  assign lane_en      = '1;
  assign lane_part    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q      <= 1'b0;
      low_q      <= 1'b0;
      beat_q     <= '0;
      len_q      <= '0;
      row0_q     <= '0;
      wr_bits    <= '0;
      burst_err  <= 1'b0;
      range_err  <= 1'b0;
      drop_err   <= 1'b0;
      orphan_err <= 1'b0;
    end else begin
      if (w_hs) begin
        if (chk_busy)
          drop_err <= 1'b1;
        else if (!act_q)
          orphan_err <= 1'b1;
      end
      if (w_take) begin
        if ((wlast != (beat_q == len_q)) || (|lane_part))
          burst_err <= 1'b1;
        if (!in_range)
          range_err <= 1'b1;
        for (int k = 0; k < LANES; k++)
          if (lane_we[k])
            wr_bits[w_ridx][k] <= 1'b1;
        beat_q <= beat_q + 8'd1;
        if (wlast)
          act_q <= 1'b0;
      end
      // A new AW replaces whatever burst is still open
      if (aw_hs) begin
        if (act_q && !(w_take && wlast))
          burst_err <= 1'b1;
        act_q  <= 1'b1;
        beat_q <= '0;
        len_q  <= awlen;
        row0_q <= {1'b0, aw_row};
        low_q  <= awaddr < BASE_A;
      end
    end
  end

  assign issue    = (state_q == CHECK) && (iss_q != n_q);
  assign iss_ridx = RW'(iss_q / LANES_W);
  assign iss_lane = LW'(iss_q % LANES_W);
  assign iss_x    = XW'(iss_q);

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++)
      if (lane_we[k])
        res_mem[k][w_ridx] <= wdata[k*OFM_DW +: OFM_DW];
    if (exp_we && !chk_busy && !rst)
      exp_mem[exp_addr] <= exp_data;
    rd_got_q <= res_mem[iss_lane][iss_ridx];
    rd_exp_q <= exp_mem[iss_x];
    rd_wr_q  <= wr_bits[iss_ridx][iss_lane];
    rd_oob_q <= iss_q >= DEPTH_W;
    rd_idx_q <= iss_q;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (chk_start) state_d = CHECK;
      CHECK:   if (iss_q == n_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chk_busy = 1'b0;
    chk_done = 1'b0;
    unique case (state_q)
      CHECK:   chk_busy = 1'b1;
      DONE: begin
        chk_busy = 1'b1;
        chk_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Unwritten or beyond-store elements report got as zero
  assign mism  = rd_oob_q | ~rd_wr_q | (rd_got_q != rd_exp_q);
  assign got_v = (rd_oob_q | ~rd_wr_q) ? '0 : rd_got_q;
  assign exp_v = rd_oob_q ? '0 : rd_exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q         <= '0;
      n_q           <= '0;
      rd_vld_q      <= 1'b0;
      err_count     <= '0;
      match_count   <= '0;
      first_seen_q  <= 1'b0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else begin
      rd_vld_q <= issue;
      if (state_q == IDLE && chk_start) begin
        n_q           <= chk_words;
        iss_q         <= '0;
        err_count     <= '0;
        match_count   <= '0;
        first_seen_q  <= 1'b0;
        first_err_idx <= '0;
        first_err_got <= '0;
        first_err_exp <= '0;
      end else begin
        if (issue)
          iss_q <= iss_q + 32'd1;
        if (rd_vld_q) begin
          if (mism) begin
            if (err_count != '1)
              err_count <= err_count + 32'd1;
            if (!first_seen_q) begin
              first_seen_q  <= 1'b1;
              first_err_idx <= rd_idx_q;
              first_err_got <= got_v;
              first_err_exp <= exp_v;
            end
          end else if (match_count != '1) begin
            match_count <= match_count + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_scoreboard.sv
// Randomized bench for axi_wr_scoreboard with an element-level reference model.
module tb_axi_wr_scoreboard;

  localparam int A     = 32;
  localparam int D     = 32;
  localparam int OW    = 16;
  localparam int DEPTH = 64;
  localparam int BASE  = 32768;
  localparam int LANES = D / OW;
  localparam int ROWS  = DEPTH / LANES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          awvalid = 1'b0, awready = 1'b1;
  logic [A-1:0]  awaddr = '0;
  logic [7:0]    awlen = '0;
  logic          wvalid = 1'b0, wready = 1'b1, wlast = 1'b0;
  logic [D-1:0]  wdata = '0;
  logic [D/8-1:0] wstrb = '1;
  logic          exp_we = 1'b0;
  logic [5:0]    exp_addr = '0;
  logic [OW-1:0] exp_data = '0;
  logic          chk_start = 1'b0;
  logic [31:0]   chk_words = '0;
  logic          chk_busy, chk_done;
  logic [31:0]   err_count, match_count, first_err_idx;
  logic [OW-1:0] first_err_got, first_err_exp;
  logic          burst_err, range_err, drop_err, orphan_err;

  always #5 clk = ~clk;

  axi_wr_scoreboard #(
    .A(A), .D(D), .OFM_DW(OW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .wdata(wdata), .wstrb(wstrb),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .chk_start(chk_start), .chk_words(chk_words),
    .chk_busy(chk_busy), .chk_done(chk_done),
    .err_count(err_count), .match_count(match_count),
    .first_err_idx(first_err_idx),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp),
    .burst_err(burst_err), .range_err(range_err),
    .drop_err(drop_err), .orphan_err(orphan_err)
  );

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  bit started = 0;

  int unsigned mres [DEPTH];
  bit          mwr  [DEPTH];
  int unsigned mexp [DEPTH];
  bit          f_burst, f_range, f_drop, f_orphan;
  bit          act;
  longint      b_addr;
  int          b_len, b_beat;
  longint      mcyc = -1;
  longint      mn = 0;
  longint      e_err, e_match, e_idx, e_got, e_exp;
  logic [31:0] bq [$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Whole-check outcome from the element arrays
  task automatic compute_expect(input longint n);
    bit seen = 0;
    e_err = 0; e_match = 0; e_idx = 0; e_got = 0; e_exp = 0;
    for (longint i = 0; i < n; i++) begin
      bit ok;
      longint g, x;
      if (i < DEPTH) begin
        x  = mexp[i];
        g  = mwr[i] ? mres[i] : 0;
        ok = mwr[i] && (mres[i] == mexp[i]);
      end else begin
        x = 0; g = 0; ok = 0;
      end
      if (ok) e_match++;
      else begin
        e_err++;
        if (!seen) begin
          seen = 1; e_idx = i; e_got = g; e_exp = x;
        end
      end
    end
  endtask

  task automatic model_apply();
    bit pre_busy;
    pre_busy = (mcyc >= 0);
    if (rst) begin
      f_burst = 0; f_range = 0; f_drop = 0; f_orphan = 0;
      act = 0; b_beat = 0; mcyc = -1;
      e_err = 0; e_match = 0; e_idx = 0; e_got = 0; e_exp = 0;
      foreach (mwr[i]) mwr[i] = 0;
      return;
    end
    if (wvalid && wready) begin
      if (pre_busy) f_drop = 1;
      else if (!act) f_orphan = 1;
      else begin
        if (wlast != (b_beat == b_len)) f_burst = 1;
        for (int k = 0; k < LANES; k++) begin
          longint e;
          bit full;
          e = (b_addr - BASE) / (D / 8) * LANES + b_beat * LANES + k;
          if (b_addr < BASE || e >= DEPTH) f_range = 1;
`ifdef SCB_WSTRB_MASK_EN
          full = &wstrb[k*2 +: 2];
          if (!full && |wstrb[k*2 +: 2]) f_burst = 1;
`else
          full = 1;
`endif
          if (full && b_addr >= BASE && e < DEPTH) begin
            mres[e] = wdata[k*OW +: OW];
            mwr[e]  = 1;
          end
        end
        b_beat++;
        if (wlast) act = 0;
      end
    end
    if (awvalid && awready) begin
      if (act) f_burst = 1;
      act = 1; b_addr = awaddr; b_len = awlen; b_beat = 0;
    end
    if (exp_we && !pre_busy) mexp[exp_addr] = exp_data;
    if (mcyc >= 0) begin
      mcyc++;
      if (mcyc > mn + 1) mcyc = -1;
    end else if (chk_start) begin
      mcyc = 0;
      mn = chk_words;
      compute_expect(mn);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_apply();
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("busy", chk_busy, mcyc >= 0);
      check("done", chk_done, mcyc == mn + 1);
      check("burst_err", burst_err, f_burst);
      check("range_err", range_err, f_range);
      check("drop_err", drop_err, f_drop);
      check("orphan_err", orphan_err, f_orphan);
      if (mcyc < 0 || mcyc == mn + 1) begin
        check("err_count", err_count, e_err);
        check("match_count", match_count, e_match);
        check("first_err_idx", first_err_idx, e_idx);
        check("first_err_got", first_err_got, e_got);
        check("first_err_exp", first_err_exp, e_exp);
      end
      if (chk_done === 1'b1) done_pulses++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic preload(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      exp_we = 1'b1; exp_addr = 6'(i); exp_data = OW'(i + 1);
      step();
    end
    exp_we = 1'b0;
  endtask

  task automatic burst(input longint addr, input int len, input int nbeats,
                       input int last_at, input logic [3:0] strb);
    awaddr = A'(addr); awlen = 8'(len); awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      int t = 0;
      if ($urandom_range(0, 3) == 0) step();
      wvalid = 1'b1; wdata = bq[b]; wstrb = strb; wlast = (b == last_at);
      do begin
        wready = (t > 3) || ($urandom_range(0, 3) != 0);
        step();
        t++;
      end while (!wready);
      wvalid = 1'b0; wlast = 1'b0; wready = 1'b1;
    end
    wstrb = '1;
  endtask

  task automatic run_check(input int n);
    chk_words = n; chk_start = 1'b1;
    step();
    chk_start = 1'b0;
    for (int k = 0; k < n + 10 && mcyc >= 0; k++) step();
    check("idle_after_check", chk_busy, 1'b0);
  endtask

  task automatic good_beats();
    bq = {32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
  endtask

  initial begin
    int p0;
    step();
    started = 1;
    rst = 1'b0;
    check("lit_reset_err", err_count, 0);
    check("lit_reset_busy", chk_busy, 0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_we = 1'b1; exp_addr = 6'(i); exp_data = OW'($urandom);
      step();
    end
    exp_we = 1'b0;
    preload(0, 8);

    good_beats();
    burst(BASE, 3, 4, 3, 4'hF);
    p0 = done_pulses;
    run_check(8);
    check("lit_match8", match_count, 8);
    check("lit_err0", err_count, 0);
    check("lit_one_done", done_pulses - p0, 1);

    do_reset();
    good_beats();
    bq[2] = 32'hBEEF_0005;
    burst(BASE, 3, 4, 3, 4'hF);
    run_check(8);
    check("lit_err1", err_count, 1);
    check("lit_idx5", first_err_idx, 5);
    check("lit_got", first_err_got, 16'hBEEF);
    check("lit_exp", first_err_exp, 16'h0006);

    p0 = done_pulses;
    run_check(0);
    check("lit_zero_err", err_count, 0);
    check("lit_zero_match", match_count, 0);
    check("lit_zero_done", done_pulses - p0, 1);

    do_reset();
    good_beats();
    burst(BASE, 3, 2, 1, 4'hF);
    check("lit_burst_err", burst_err, 1);
    check("lit_no_orphan", orphan_err, 0);
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0;
    check("lit_orphan", orphan_err, 1);

    do_reset();
    burst(BASE + 4 * DEPTH, 1, 2, 1, 4'hF);
    check("lit_range", range_err, 1);
    run_check(DEPTH + 4);
    check("lit_range_errs", err_count, DEPTH + 4);
    check("lit_range_match", match_count, 0);

    do_reset();
    good_beats();
    burst(BASE, 3, 4, 3, 4'hF);
    p0 = done_pulses;
    chk_words = 8; chk_start = 1'b1;
    step();
    chk_start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("lit_abort_busy", chk_busy, 0);
    check("lit_abort_cnt", err_count | match_count, 0);
    repeat (12) step();
    check("lit_abort_nodone", done_pulses - p0, 0);
    preload(0, 8);
    burst(BASE, 3, 4, 3, 4'hF);
    run_check(8);
    check("lit_recheck", match_count, 8);

    do_reset();
    chk_words = 8; chk_start = 1'b1;
    step();
    chk_start = 1'b0;
    wvalid = 1'b1; wready = 1'b1; wdata = $urandom;
    step();
    wvalid = 1'b0;
    for (int k = 0; k < 20 && mcyc >= 0; k++) step();
    check("lit_drop", drop_err, 1);
    check("lit_drop_no_orphan", orphan_err, 0);

`ifdef SCB_WSTRB_MASK_EN
    do_reset();
    bq = {32'h0002_0001};
    burst(BASE, 0, 1, 0, 4'b0011);
    run_check(2);
    check("lit_strb_err", err_count, 1);
    check("lit_strb_idx", first_err_idx, 1);
`endif

    for (int it = 0; it < 30; it++) begin
      int nb;
      if ($urandom_range(0, 2) == 0) do_reset();
      repeat ($urandom_range(1, 6)) begin
        int a = $urandom_range(0, DEPTH - 1);
        exp_we = 1'b1; exp_addr = 6'(a);
        exp_data = (mwr[a] && $urandom_range(0, 1)) ? OW'(mres[a]) : OW'($urandom);
        step();
      end
      exp_we = 1'b0;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        int len = $urandom_range(0, 5);
        int mode = $urandom_range(0, 7);
        longint addr = BASE + 4 * $urandom_range(0, ROWS - 1 - len);
        int nbeats = len + 1;
        int last_at = len;
        if (mode == 0) begin
          nbeats = (len > 0) ? len : 2;
          last_at = nbeats - 1;
        end else if (mode == 1) begin
          addr = $urandom_range(0, 1) ? BASE - 8 : BASE + 4 * (ROWS - 2);
        end
        bq = {};
        for (int j = 0; j < nbeats; j++) begin
          logic [31:0] w;
          for (int k = 0; k < LANES; k++) begin
            longint e = (addr - BASE) / 4 * LANES + j * LANES + k;
            if (addr >= BASE && e < DEPTH && $urandom_range(0, 3) != 0)
              w[k*OW +: OW] = OW'(mexp[e]);
            else
              w[k*OW +: OW] = OW'($urandom);
          end
          bq.push_back(w);
        end
        burst(addr, len, nbeats, last_at, 4'hF);
      end
      run_check($urandom_range(0, DEPTH + 3));
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_scoreboard.md
AXI_WR_SCOREBOARD -- requirements
Module: axi_wr_scoreboard

Interface
REQ-001 Parameter A, default 32: AXI address width.
REQ-002 Parameter D, default 32: AXI data width; must be a multiple of OFM_DW.
REQ-003 Parameter OFM_DW, default 16: element width; LANES = D/OFM_DW elements per beat.
REQ-004 Parameter DEPTH, default 65536: element capacity of both the result store and the expect store.
REQ-005 Parameter BASE_ADDR, default 32768: byte address that maps to element index 0.
REQ-006 Port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Ports awvalid/awready, input, 1 each; awaddr, input, A; awlen, input, 8: snooped AW channel.
REQ-009 Ports wvalid/wready/wlast, input, 1 each; wdata, input, D; wstrb, input, D/8: snooped W channel.
REQ-010 Ports exp_we, input, 1; exp_addr, input, $clog2(DEPTH); exp_data, input, OFM_DW: expect-store preload port.
REQ-011 Ports chk_start, input, 1; chk_words, input, 32: check request and the number of elements to check.
REQ-012 Ports chk_busy and chk_done, output, 1 each: checker status.
REQ-013 Ports err_count and match_count, output, 32 each: check results.
REQ-014 Ports first_err_idx, output, 32; first_err_got and first_err_exp, output, OFM_DW each: details of the first mismatch.
REQ-015 Ports burst_err, range_err, drop_err and orphan_err, output, 1 each: sticky protocol flags.

Function
REQ-016 The block is passive: it drives nothing onto the AXI channels.
REQ-017 On an AW handshake (awvalid & awready) the block latches base_beat = (awaddr - BASE_ADDR)/(D/8) and awlen, clears the beat counter, and marks a burst active.
REQ-018 On each W handshake, element index base_beat*LANES + beat*LANES + k receives wdata lane k, for k = 0..LANES-1, and its written bit is set.
REQ-019 The beat counter increments on each W handshake; the burst ends on the beat carrying wlast.
REQ-020 burst_err is set if wlast is asserted on any beat other than beat awlen, or is absent on beat awlen.
REQ-021 A W handshake with no burst active is dropped and sets orphan_err.
REQ-022 An AW handshake while a burst is still active overrides the active burst and sets burst_err.
REQ-023 An element whose index is below BASE_ADDR or at/above DEPTH is not written and sets range_err; the other lanes of that beat are still written.
REQ-024 Checker FSM states: IDLE -> CHECK on chk_start.
REQ-025 In CHECK, one element is compared per cycle; the store read latency is 1 cycle.
REQ-026 CHECK -> DONE after chk_words comparisons; DONE -> IDLE after exactly one cycle.
REQ-027 chk_done is a 1-cycle pulse in DONE; chk_busy is high in CHECK and DONE.
REQ-028 An element mismatches if it is unwritten or got !== exp; otherwise it matches.
REQ-029 On the first mismatch, first_err_idx, first_err_got and first_err_exp are latched; later mismatches do not change them.
REQ-030 err_count and match_count clear on entry to CHECK and saturate at 2^32-1.
REQ-031 chk_start while busy is ignored.
REQ-032 chk_words = 0 passes from CHECK to DONE in one cycle with both counts 0.
REQ-033 chk_words > DEPTH counts every element beyond DEPTH as a mismatch.
REQ-034 W beats arriving while chk_busy is high are dropped and set drop_err.
REQ-035 exp_we has priority over nothing: the expect store is single-writer, and exp_we is ignored while busy.

Reset
REQ-036 rst clears: FSM to IDLE, burst active, beat counter, all written bits, all counts, all first_err_* outputs, all sticky flags, chk_busy and chk_done.
REQ-037 rst does not clear the contents of the result store or the expect store.
REQ-038 rst asserted mid-CHECK aborts the check with no chk_done pulse.

Configuration
REQ-039 Macro SCB_WSTRB_MASK_EN defined: lane k is written only if wstrb[k*OFM_DW/8 +: OFM_DW/8] is all ones; a partially strobed lane sets burst_err.
REQ-040 Macro SCB_WSTRB_MASK_EN undefined: wstrb is ignored and all lanes are written.

Verification
REQ-041 Preload expect[0..7] = 0x0001..0x0008; one AW at 32768 with awlen = 3 and matching 4 beats; check 8 -> match_count = 8, err_count = 0, one chk_done pulse.
REQ-042 As REQ-041 but beat 2 lane 1 = 0xBEEF -> err_count = 1, first_err_idx = 5, got = 0xBEEF, exp = 0x0006.
REQ-043 AW with awlen = 3 and wlast on beat 1 -> burst_err = 1; a W beat with no AW -> orphan_err = 1.
REQ-044 AW at 32768 + 4*DEPTH -> range_err = 1, no element written; a later check counts those indices as unwritten errors.
REQ-045 Assert rst during CHECK at comparison 3 of 8 -> chk_busy = 0 next cycle, counts = 0, no chk_done; a re-check after re-preload passes.
REQ-046 With SCB_WSTRB_MASK_EN, wstrb = 4'b0011 -> lane 0 written, lane 1 unwritten -> 1 error on check.
